lock_ctrl_sequencer: RTL and testbench

//  Sequenced controller for the enable/lock control pair. Accepts 4-bit control

---
 rtl/lock_ctrl_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_lock_ctrl_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lock_ctrl_sequencer.sv
// lock_ctrl_sequencer
// Command-driven controller for the enable/lock control pair. Commands arrive
// over a valid/ready handshake; enable requests wait out a settle period
// before enable_all asserts, and lock is sticky until reset. Rejected
// commands are counted in a saturating error counter.

module lock_ctrl_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       control_signal,
    output logic             enable_all,
    output logic             lock_on,
    output logic             busy,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic [CNT_W-1:0] err_count
);

    // Settle counter only has to hold SETTLE_CYCLES-1.
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENABLING = 2'd1,
        ST_ENABLED  = 2'd2,
        ST_LOCKED   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_ENABLE  = 2'd0,
        CMD_DISABLE = 2'd1,
        CMD_LOCK    = 2'd2,
        CMD_INVALID = 2'd3
    } cmd_t;

    state_t           state_q, state_d;
    logic [SET_W-1:0] cnt_q, cnt_d;
    logic             enable_q, enable_d;
    logic             lock_q, lock_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    cmd_t             cmd;
    logic             accept;

    // Decode the raw command code; anything outside the three legal codes is rejected.
    always_comb begin
        unique case (control_signal)
            4'b0001: cmd = CMD_ENABLE;
            4'b0010: cmd = CMD_DISABLE;
            4'b0011: cmd = CMD_LOCK;
            default: cmd = CMD_INVALID;
        endcase
    end

    // NOTE: ready is decoded straight from the state register (not registered
    // again) so it drops in the very cycle ENABLING is entered.
    assign cmd_ready = (state_q != ST_ENABLING);
    assign busy      = (state_q == ST_ENABLING);
    assign accept    = cmd_valid && cmd_ready;

    // Next-state, settle counter and response-pulse logic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_DISABLED: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_ENABLE: begin
                            // Completion is reported when the settle ends, not now.
                            state_d = ST_ENABLING;
                            cnt_d   = SETTLE_LOAD;
                        end
                        CMD_DISABLE: done_d = 1'b1;
                        CMD_LOCK: begin
                            state_d = ST_LOCKED;
                            done_d  = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            ST_ENABLING: begin
                // No command can be accepted here; just run out the settle time.
                if (cnt_q == '0) begin
                    state_d = ST_ENABLED;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_ENABLED: begin
                if (accept) begin
                    unique case (cmd)
                        CMD_ENABLE: done_d = 1'b1;
                        CMD_DISABLE: begin
                            state_d = ST_DISABLED;
                            done_d  = 1'b1;
                        end
                        CMD_LOCK: begin
                            state_d = ST_LOCKED;
                            done_d  = 1'b1;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end

            ST_LOCKED: begin
                // Sticky: only a repeated LOCK succeeds, everything else is refused.
                if (accept) begin
                    if (cmd == CMD_LOCK) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            default: state_d = ST_DISABLED;
        endcase

        if (err_d && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Control outputs follow the state being entered, so they change on the accept edge.
    always_comb begin
        enable_d = (state_d == ST_ENABLED);
        lock_d   = (state_d == ST_LOCKED);
    end

    // State and output registers; reset wins over any simultaneous accept.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= ST_DISABLED;
            cnt_q     <= '0;
            enable_q  <= 1'b0;
            lock_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            enable_q  <= enable_d;
            lock_q    <= lock_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign enable_all = enable_q;
    assign lock_on    = lock_q;
    assign cmd_done   = done_q;
    assign cmd_err    = err_q;
    assign err_count  = err_cnt_q;

    // Output invariants: the control pair and the response pulses are mutually exclusive.
    a_en_lock_excl : assert property (@(posedge clk) disable iff (rst)
        !(enable_all && lock_on));
    a_done_err_excl : assert property (@(posedge clk) disable iff (rst)
        !(cmd_done && cmd_err));

endmodule

// File: tb/tb_lock_ctrl_sequencer.sv
// tb_lock_ctrl_sequencer
// Directed-vector bench for lock_ctrl_sequencer (SETTLE_CYCLES=4, CNT_W=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_lock_ctrl_sequencer;

    localparam int SETTLE = 4;
    localparam int CW     = 8;

    localparam logic [3:0] C_ENABLE  = 4'b0001;
    localparam logic [3:0] C_DISABLE = 4'b0010;
    localparam logic [3:0] C_LOCK    = 4'b0011;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    control_signal;
    logic          enable_all;
    logic          lock_on;
    logic          busy;
    logic          cmd_done;
    logic          cmd_err;
    logic [CW-1:0] err_count;

    int checks = 0;
    int errors = 0;

    lock_ctrl_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .control_signal(control_signal),
        .enable_all    (enable_all),
        .lock_on       (lock_on),
        .busy          (busy),
        .cmd_done      (cmd_done),
        .cmd_err       (cmd_err),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then check the mutual-exclusion invariants.
    task automatic step();
        @(posedge clk);
        #1;
        check("excl_en_lock", {31'd0, enable_all & lock_on}, 32'd0);
        check("excl_done_err", {31'd0, cmd_done & cmd_err}, 32'd0);
    endtask

    // Compare the full visible output set against expectations.
    task automatic expect_all(input string tag, input logic rdy, input logic en,
                              input logic lk, input logic bsy, input logic dn,
                              input logic er, input int cnt);
        check({tag, "_ready"}, {31'd0, cmd_ready}, {31'd0, rdy});
        check({tag, "_en"},    {31'd0, enable_all}, {31'd0, en});
        check({tag, "_lock"},  {31'd0, lock_on},   {31'd0, lk});
        check({tag, "_busy"},  {31'd0, busy},      {31'd0, bsy});
        check({tag, "_done"},  {31'd0, cmd_done},  {31'd0, dn});
        check({tag, "_err"},   {31'd0, cmd_err},   {31'd0, er});
        check({tag, "_cnt"},   {24'd0, err_count}, cnt);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Issue one command for exactly one accept edge.
    task automatic send(input logic [3:0] code);
        cmd_valid      = 1'b1;
        control_signal = code;
        step();
        cmd_valid      = 1'b0;
    endtask

    // ENABLE from DISABLED, then run out the settle period.
    task automatic go_enabled(input string tag, input int cnt);
        send(C_ENABLE);
        for (int i = 0; i < SETTLE - 1; i++) step();
        step();
        expect_all(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, cnt);
        step();
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        control_signal = 4'b0000;

        // 1: reset state, then ENABLE with settle timing.
        do_reset();
        expect_all("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send(C_ENABLE);                          // edge 0
        for (int i = 0; i < SETTLE; i++) begin    // cycles after edges 0..3
            expect_all($sformatf("settle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
            step();
        end
        expect_all("enabled", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);   // after edge 4
        step();
        expect_all("en_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 2: DISABLE from ENABLED, then an invalid code.
        send(C_DISABLE);
        expect_all("disable", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        send(4'b0111);
        expect_all("inval", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        step();
        expect_all("inval_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // 3: LOCK from ENABLED is sticky.
        go_enabled("reen", 1);
        send(C_LOCK);
        expect_all("lock", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        send(C_ENABLE);
        expect_all("lk_en", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        send(C_DISABLE);
        expect_all("lk_dis", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        send(C_LOCK);
        expect_all("lk_lock", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3);

        // 4: reset two cycles into ENABLING discards the settle.
        do_reset();
        expect_all("rst2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        send(C_ENABLE);                          // edge 0
        step();                                  // edge 1
        rst = 1'b1;
        step();                                  // edge 2: reset
        rst = 1'b0;
        expect_all("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < SETTLE; i++) step();
        expect_all("no_late_done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Reset dominates an accept on the same edge.
        rst            = 1'b1;
        cmd_valid      = 1'b1;
        control_signal = C_LOCK;
        step();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        expect_all("rst_dom", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 5: held invalid command saturates err_count.
        do_reset();
        cmd_valid      = 1'b1;
        control_signal = 4'b1111;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (i == 1)   check("sat_1",   {24'd0, err_count}, 32'd1);
            if (i == 254) check("sat_254", {24'd0, err_count}, 32'd254);
            if (i == 255) check("sat_255", {24'd0, err_count}, 32'd255);
        end
        expect_all("sat_end", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 255);
        cmd_valid = 1'b0;
        step();
        check("sat_hold", {24'd0, err_count}, 32'd255);

        // 6: ENABLE held through ENABLING is not accepted until ENABLED.
        do_reset();
        cmd_valid      = 1'b1;
        control_signal = C_ENABLE;
        step();                                  // edge 0: accept
        for (int i = 1; i < SETTLE; i++) begin
            step();                              // edges 1..3: ready low
            expect_all($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        end
        step();                                  // edge 4: settle done
        expect_all("hold_en", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        step();                                  // edge 5: re-accept ENABLE
        expect_all("hold_re", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        cmd_valid = 1'b0;
        step();
        expect_all("hold_idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
